ysyx_24080006_lsu: RTL and testbench
====================================

YSYX_24080006_LSU -- requirements
Module: ysyx_24080006_lsu

Interface
REQ-001 SHALL have no parameters; data and address widths are fixed at 32 bits.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clock  in  1  rising-edge clock.
REQ-003 SHALL provide: reset  in  1  asynchronous active-high reset.
REQ-004 SHALL provide upstream (execute) ports: in_valid in 1, in_ready out 1, in_pc in 32, in_alu_res in 32 (result or effective address), in_sdata in 32 (store data), in_funct3 in 3, in_rd_addr in 5, in_load in 1, in_store in 1, in_wb in 1.
REQ-005 SHALL provide downstream (writeback) ports: out_valid out 1, out_ready in 1, out_pc out 32, out_rd_addr out 5, out_wb out 1 (register write enable), out_wdata out 32, out_err out 1 (misaligned access).
REQ-006 SHALL provide memory ports: mem_valid out 1, mem_ready in 1 (request accepted), mem_addr out 32, mem_wen out 1, mem_wdata out 32, mem_wstrb out 4, mem_rvalid in 1 (response), mem_rdata in 32.

Function
REQ-007 SHALL implement FSM states IDLE, REQ, WAIT, OUT; in_ready = 1 only in IDLE, so at most one operation is in flight.
REQ-008 An upstream transfer SHALL occur on a cycle with in_valid && in_ready; all in_* fields are registered on that edge.
REQ-009 Non-memory op (in_load = in_store = 0): IDLE -> OUT; out_wdata = in_alu_res; out_valid is asserted the cycle after acceptance.
REQ-010 Aligned load/store: IDLE -> REQ; mem_valid is held with stable address, data and strobe until mem_ready; REQ -> WAIT on mem_ready.
REQ-011 WAIT -> OUT on mem_rvalid; a store SHALL wait for mem_rvalid as its write acknowledge; mem_rdata is ignored for stores.
REQ-012 OUT: out_valid held with stable fields until out_ready; OUT -> IDLE on out_ready; no bubble-free back-to-back acceptance (next accept is earliest the cycle after the OUT handshake).
REQ-013 mem_addr = {addr[31:2], 2'b00}; off = addr[1:0]; mem_wen = in_store.
REQ-014 Store strobe: SB 4'b0001<<off, SH 4'b0011<<off, SW 4'b1111; mem_wdata = sdata << (8*off).
REQ-015 Load extract: rdata >> (8*off); LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; funct3 000/001/010/100/101.
REQ-016 Misaligned (H with addr[0]=1, W with addr[1:0]!=0): no memory transaction; IDLE -> OUT with out_err = 1, out_wb = 0.
REQ-017 out_wb = in_wb && !misaligned; stores force out_wb = 0.
REQ-018 mem_rvalid outside WAIT and mem_ready outside REQ SHALL be ignored.
REQ-019 A store's memory write SHALL NOT be issued twice; once mem_ready is seen, mem_valid deasserts in the next cycle.

Reset
REQ-020 On reset assertion, the FSM SHALL enter IDLE immediately and asynchronously; out_valid, mem_valid, mem_wen, out_err, out_wb = 0; mem_wstrb = 0; data registers = 0.
REQ-021 Reset mid-operation (REQ/WAIT/OUT) SHALL abandon the operation; a late mem_rvalid after reset release is ignored; in_ready = 1 on the first edge after release.

Verification
REQ-022 ALU op: in_alu_res=0x1234, in_wb=1, rd=5 -> out_valid the next cycle, out_wdata=0x1234, out_wb=1, no mem_valid.
REQ-023 LB at 0x8000_0003, mem_rdata=0x80AA_BBCC -> mem_addr=0x8000_0000, out_wdata=0xFFFF_FF80.
REQ-024 SH at 0x8000_0002, sdata=0x0000_BEEF -> mem_wstrb=4'b1100, mem_wdata=0xBEEF_0000, mem_wen=1; out_wb=0 after mem_rvalid.
REQ-025 LW at 0x8000_0001 -> no mem_valid, out_err=1, out_wb=0 the next cycle.
REQ-026 Hold mem_ready=0 for 3 cycles, then out_ready=0 for 2 cycles -> mem_*, out_* stable throughout; in_ready=0 until the OUT handshake.
REQ-027 Reset asserted while in WAIT, then mem_rvalid pulse after release -> out_valid stays 0, in_ready=1.

Source files
------------

// File: rtl/ysyx_24080006_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24080006_lsu
//  Description : Single-outstanding load/store unit between execute and
//                writeback. Non-memory ops pass straight through. Misaligned
//                accesses are flagged and never reach memory. Aligned
//                loads/stores are issued as one request followed by one
//                response.
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_24080006_lsu (
    input  logic        clock,
    input  logic        reset,
    // upstream (execute)
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_alu_res,
    input  logic [31:0] in_sdata,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd_addr,
    input  logic        in_load,
    input  logic        in_store,
    input  logic        in_wb,
    // downstream (writeback)
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rd_addr,
    output logic        out_wb,
    output logic [31:0] out_wdata,
    output logic        out_err,
    // memory
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] pc_q,        pc_d;
    logic [4:0]  rd_q,        rd_d;
    logic        wb_q,        wb_d;
    logic [31:0] wdata_q,     wdata_d;
    logic        err_q,       err_d;
    logic        mvalid_q,    mvalid_d;
    logic [31:0] maddr_q,     maddr_d;
    logic        wen_q,       wen_d;
    logic [31:0] mwdata_q,    mwdata_d;
    logic [3:0]  wstrb_q,     wstrb_d;
    logic [2:0]  funct3_q,    funct3_d;
    logic [1:0]  off_q,       off_d;

    logic [1:0]  w_off;
    logic        w_mem_op;
    logic        w_misaligned;
    logic [3:0]  w_strb;
    logic [31:0] w_rshift;
    logic [31:0] w_load_val;

    assign w_off    = in_alu_res[1:0];
    assign w_mem_op = in_load | in_store;
    assign w_rshift = mem_rdata >> {off_q, 3'b000};

    // Alignment check and byte-lane strobe for the incoming access
    always_comb begin
        w_misaligned = 1'b0;
        w_strb       = 4'b1111;
        case (in_funct3[1:0])
            2'b00: w_strb = 4'b0001 << w_off;
            2'b01: begin
                w_strb       = 4'b0011 << w_off;
                w_misaligned = w_off[0];
            end
            default: begin
                w_strb       = 4'b1111;
                w_misaligned = (w_off != 2'b00);
            end
        endcase
    end

    // Lane extraction plus sign/zero extension of returned load data
    always_comb begin
        w_load_val = w_rshift;
        case (funct3_q)
            3'b000:  w_load_val = {{24{w_rshift[7]}},  w_rshift[7:0]};
            3'b001:  w_load_val = {{16{w_rshift[15]}}, w_rshift[15:0]};
            3'b100:  w_load_val = {24'd0, w_rshift[7:0]};
            3'b101:  w_load_val = {16'd0, w_rshift[15:0]};
            default: w_load_val = w_rshift;
        endcase
    end

    // Next-state and next-output computation for the one-in-flight FSM
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        pc_d        = pc_q;
        rd_d        = rd_q;
        wb_d        = wb_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        mvalid_d    = mvalid_q;
        maddr_d     = maddr_q;
        wen_d       = wen_q;
        mwdata_d    = mwdata_q;
        wstrb_d     = wstrb_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    pc_d     = in_pc;
                    rd_d     = in_rd_addr;
                    funct3_d = in_funct3;
                    off_d    = w_off;
                    wdata_d  = in_alu_res;
                    maddr_d  = {in_alu_res[31:2], 2'b00};
                    wen_d    = 1'b0;
                    wstrb_d  = 4'b0000;
                    mwdata_d = 32'd0;
                    err_d    = 1'b0;
                    if (!w_mem_op) begin
                        state_d     = S_OUT;
                        out_valid_d = 1'b1;
                        wb_d        = in_wb;
                    end else if (w_misaligned) begin
                        // Flag and skip memory entirely
                        state_d     = S_OUT;
                        out_valid_d = 1'b1;
                        err_d       = 1'b1;
                        wb_d        = 1'b0;
                    end else begin
                        state_d  = S_REQ;
                        mvalid_d = 1'b1;
                        wen_d    = in_store;
                        wstrb_d  = w_strb;
                        mwdata_d = in_sdata << {w_off, 3'b000};
                        wb_d     = in_wb & ~in_store;
                    end
                end
            end
            S_REQ: begin
                // Drop the request right after acceptance so it issues once
                if (mem_ready) begin
                    state_d  = S_WAIT;
                    mvalid_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d     = S_OUT;
                    out_valid_d = 1'b1;
                    if (!wen_q) begin
                        wdata_d = w_load_val;
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            pc_q        <= 32'd0;
            rd_q        <= 5'd0;
            wb_q        <= 1'b0;
            wdata_q     <= 32'd0;
            err_q       <= 1'b0;
            mvalid_q    <= 1'b0;
            maddr_q     <= 32'd0;
            wen_q       <= 1'b0;
            mwdata_q    <= 32'd0;
            wstrb_q     <= 4'd0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            rd_q        <= rd_d;
            wb_q        <= wb_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            mvalid_q    <= mvalid_d;
            maddr_q     <= maddr_d;
            wen_q       <= wen_d;
            mwdata_q    <= mwdata_d;
            wstrb_q     <= wstrb_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = out_valid_q;
    assign out_pc      = pc_q;
    assign out_rd_addr = rd_q;
    assign out_wb      = wb_q;
    assign out_wdata   = wdata_q;
    assign out_err     = err_q;
    assign mem_valid   = mvalid_q;
    assign mem_addr    = maddr_q;
    assign mem_wen     = wen_q;
    assign mem_wdata   = mwdata_q;
    assign mem_wstrb   = wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24080006_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_24080006_lsu
//  Description : Directed vector bench for the load/store unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ysyx_24080006_lsu;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_alu_res, in_sdata;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd_addr;
    logic        in_load, in_store, in_wb;
    logic        out_valid, out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rd_addr;
    logic        out_wb;
    logic [31:0] out_wdata;
    logic        out_err;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    ysyx_24080006_lsu dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_alu_res(in_alu_res), .in_sdata(in_sdata), .in_funct3(in_funct3),
        .in_rd_addr(in_rd_addr), .in_load(in_load), .in_store(in_store),
        .in_wb(in_wb),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd_addr(out_rd_addr), .out_wb(out_wb), .out_wdata(out_wdata),
        .out_err(out_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [2:0]  f3;
        logic        ld;
        logic        st;
        logic        wb;
        logic [4:0]  rd;
        logic        emem;
        logic [3:0]  estrb;
        logic [31:0] emwdata;
        logic [31:0] eout;
        logic        ewb;
        logic        eerr;
        logic        chkout;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic [31:0] pc, input vec_t v);
        in_valid   = 1'b1;
        in_pc      = pc;
        in_alu_res = v.addr;
        in_sdata   = v.sdata;
        in_funct3  = v.f3;
        in_rd_addr = v.rd;
        in_load    = v.ld;
        in_store   = v.st;
        in_wb      = v.wb;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] pc;
        pc = 32'h100 + 32'(idx) * 4;
        @(negedge clock);
        chk($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, 32'd1);
        drive_op(pc, v);
        @(negedge clock);
        in_valid = 1'b0;
        chk($sformatf("v%0d in_ready_busy", idx), {31'd0, in_ready}, 32'd0);
        chk($sformatf("v%0d mem_valid", idx), {31'd0, mem_valid}, {31'd0, v.emem});
        if (v.emem) begin
            chk($sformatf("v%0d mem_addr", idx), mem_addr, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d mem_wen", idx), {31'd0, mem_wen}, {31'd0, v.st});
            if (v.st) begin
                chk($sformatf("v%0d mem_wstrb", idx), {28'd0, mem_wstrb}, {28'd0, v.estrb});
                chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.emwdata);
            end
            chk($sformatf("v%0d early_out", idx), {31'd0, out_valid}, 32'd0);
            mem_ready = 1'b1;
            @(negedge clock);
            mem_ready = 1'b0;
            chk($sformatf("v%0d mem_valid_drop", idx), {31'd0, mem_valid}, 32'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
            @(negedge clock);
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
        chk($sformatf("v%0d out_valid", idx), {31'd0, out_valid}, 32'd1);
        chk($sformatf("v%0d out_pc", idx), out_pc, pc);
        chk($sformatf("v%0d out_rd", idx), {27'd0, out_rd_addr}, {27'd0, v.rd});
        chk($sformatf("v%0d out_wb", idx), {31'd0, out_wb}, {31'd0, v.ewb});
        chk($sformatf("v%0d out_err", idx), {31'd0, out_err}, {31'd0, v.eerr});
        if (v.chkout)
            chk($sformatf("v%0d out_wdata", idx), out_wdata, v.eout);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk($sformatf("v%0d out_drop", idx), {31'd0, out_valid}, 32'd0);
        chk($sformatf("v%0d mem_idle", idx), {31'd0, mem_valid}, 32'd0);
    endtask

    initial begin
        vec_t s;
        // addr, sdata, rdata, f3, ld, st, wb, rd, emem, estrb, emwdata, eout, ewb, eerr, chkout
        vecs[0]  = '{32'h0000_1234, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd5,
                     1'b0, 4'h0, 32'h0, 32'h0000_1234, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{32'h8000_0003, 32'h0, 32'h80AA_BBCC, 3'b000, 1'b1, 1'b0, 1'b1, 5'd6,
                     1'b1, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{32'h8000_0002, 32'h0000_BEEF, 32'h5555_5555, 3'b001, 1'b0, 1'b1, 1'b1, 5'd7,
                     1'b1, 4'b1100, 32'hBEEF_0000, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'h8000_0001, 32'h0, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd8,
                     1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{32'h8000_0001, 32'h0, 32'h80AA_BBCC, 3'b100, 1'b1, 1'b0, 1'b1, 5'd9,
                     1'b1, 4'h0, 32'h0, 32'h0000_00BB, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{32'h8000_0002, 32'h0, 32'h80AA_BBCC, 3'b001, 1'b1, 1'b0, 1'b1, 5'd10,
                     1'b1, 4'h0, 32'h0, 32'hFFFF_80AA, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{32'h8000_0000, 32'h0, 32'h80AA_BBCC, 3'b101, 1'b1, 1'b0, 1'b1, 5'd11,
                     1'b1, 4'h0, 32'h0, 32'h0000_BBCC, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{32'h8000_0004, 32'h0, 32'h1234_5678, 3'b010, 1'b1, 1'b0, 1'b1, 5'd12,
                     1'b1, 4'h0, 32'h0, 32'h1234_5678, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{32'h8000_0001, 32'h0000_00A5, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0, 5'd13,
                     1'b1, 4'b0010, 32'h0000_A500, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h8000_0008, 32'hDEAD_BEEF, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 5'd14,
                     1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'h8000_0003, 32'h0000_1111, 32'h0, 3'b001, 1'b0, 1'b1, 1'b0, 5'd15,
                     1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{32'h8000_0001, 32'h0, 32'h0, 3'b001, 1'b1, 1'b0, 1'b1, 5'd16,
                     1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};

        reset = 1'b1;
        in_valid = 1'b0; in_pc = 32'h0; in_alu_res = 32'h0; in_sdata = 32'h0;
        in_funct3 = 3'b0; in_rd_addr = 5'd0; in_load = 1'b0; in_store = 1'b0; in_wb = 1'b0;
        out_ready = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        repeat (2) @(negedge clock);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst mem_wen",   {31'd0, mem_wen},   32'd0);
        chk("rst out_err",   {31'd0, out_err},   32'd0);
        chk("rst out_wb",    {31'd0, out_wb},    32'd0);
        chk("rst mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst out_wdata", out_wdata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Stalled memory and stalled writeback with a stray response in REQ
        s = vecs[7];
        s.addr = 32'h8000_0010;
        s.rdata = 32'hCAFE_F00D;
        @(negedge clock);
        drive_op(32'h200, s);
        @(negedge clock);
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mem_rvalid = (c == 1);
            chk($sformatf("stall%0d mem_valid", c), {31'd0, mem_valid}, 32'd1);
            chk($sformatf("stall%0d mem_addr", c), mem_addr, 32'h8000_0010);
            chk($sformatf("stall%0d in_ready", c), {31'd0, in_ready}, 32'd0);
            @(negedge clock);
        end
        mem_rvalid = 1'b0;
        chk("stall3 mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("stall3 out_valid", {31'd0, out_valid}, 32'd0);
        mem_ready = 1'b1;
        @(negedge clock);
        mem_ready = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clock);
        mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("ohold%0d out_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("ohold%0d out_wdata", c), out_wdata, 32'hCAFE_F00D);
            chk($sformatf("ohold%0d out_pc", c), out_pc, 32'h200);
            chk($sformatf("ohold%0d in_ready", c), {31'd0, in_ready}, 32'd0);
            @(negedge clock);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("ohold done", {31'd0, out_valid}, 32'd0);
        chk("ohold in_ready", {31'd0, in_ready}, 32'd1);

        // Reset while waiting for the response, then a late response
        @(negedge clock);
        drive_op(32'h300, vecs[7]);
        @(negedge clock);
        in_valid = 1'b0;
        mem_ready = 1'b1;
        @(negedge clock);
        mem_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("arst in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h1111_2222;
        @(negedge clock);
        mem_rvalid = 1'b0;
        chk("late out_valid", {31'd0, out_valid}, 32'd0);
        chk("late in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        chk("late out_valid2", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
